// File: rtl/queue_drain_ctrl_pkg.sv
// mc_pkg: shared state encoding, default widths and watermark sanity check for queue_drain_ctrl
package mc_pkg;
  typedef enum logic [1:0] {IDLE, POP, WAIT, HOLD} state_t;
  localparam int DATA_W_D = 8;
  localparam int LEN_W_D = 4;
  localparam int DEPTH_D = 8;
  function automatic bit wm_ok(input int low_wm, input int high_wm, input int depth);
    return low_wm < high_wm && high_wm <= depth;
  endfunction
endpackage

// File: rtl/queue_drain_ctrl_wm.sv
// flow_ctrl_wm: registered watermark hysteresis driving the deserializer accept line
module flow_ctrl_wm #(
  parameter int LEN_W = 4,
  parameter int HIGH_WM = 6,
  parameter int LOW_WM = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LEN_W-1:0] len_in,
  output logic             accept_out
);
  always_ff @(posedge clock or posedge reset)
    if (reset) accept_out <= 1'b1;
    else if (len_in >= LEN_W'(HIGH_WM)) accept_out <= 1'b0;
    else if (len_in <= LEN_W'(LOW_WM)) accept_out <= 1'b1;
endmodule

// File: rtl/queue_drain_ctrl.sv
// queue_drain_ctrl: pops the queue one word at a time and forwards it over valid/ready; QDRAIN_BURST_EN enables burst draining
module queue_drain_ctrl
  import mc_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LEN_W = LEN_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int HIGH_WM = 6,
  parameter int LOW_WM = 2,
  parameter int DEQ_LAT = 1
`ifdef QDRAIN_BURST_EN
  ,
  parameter int BURST_LEN = 4
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic              accept_out,
  output logic [DATA_W-1:0] m_data_out,
  output logic              m_valid_out,
  input  logic              m_ready_in,
  output logic              busy_out
);
  if (!wm_ok(LOW_WM, HIGH_WM, DEPTH) || DEQ_LAT < 1 || DEQ_LAT > 7) begin : g_bad_cfg
    $error("queue_drain_ctrl: illegal watermark or latency configuration");
  end
  state_t state, nxt;
  logic [2:0] cnt;
  logic start_c, cont_c;
`ifdef QDRAIN_BURST_EN
  logic burst;
  assign start_c = len_in >= LEN_W'(BURST_LEN);
  // once a burst is running, keep popping until the queue is empty
  assign cont_c = burst ? len_in != '0 : start_c;
  always_ff @(posedge clock or posedge reset)
    if (reset) burst <= 1'b0;
    else if (nxt == IDLE) burst <= 1'b0;
    else if (state == IDLE && nxt == POP) burst <= 1'b1;
`else
  assign start_c = len_in != '0;
  assign cont_c = start_c;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = enable_in && start_c ? POP : IDLE;
      POP: nxt = WAIT;
      WAIT: nxt = cnt <= 3'd1 ? HOLD : WAIT;
      HOLD: nxt = !m_ready_in ? HOLD : enable_in && cont_c ? POP : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    dequeue_out = state == POP;
    busy_out = state != IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      m_data_out <= '0;
      m_valid_out <= 1'b0;
    end else begin
      if (state == POP) cnt <= 3'(DEQ_LAT);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 3'd1;
      if (state == WAIT && nxt == HOLD) begin
        m_data_out <= data_in;
        m_valid_out <= 1'b1;
      end else if (state == HOLD && m_ready_in) m_valid_out <= 1'b0;
    end
  flow_ctrl_wm #(.LEN_W(LEN_W), .HIGH_WM(HIGH_WM), .LOW_WM(LOW_WM)) u_wm (
    .clock(clock),
    .reset(reset),
    .len_in(len_in),
    .accept_out(accept_out)
  );
endmodule

// File: tb/tb_queue_drain_ctrl.sv
// tb_queue_drain_ctrl: queue model + scoreboard bench for queue_drain_ctrl
module tb_queue_drain_ctrl;
  localparam int DEQ_LAT = 1;
`ifdef QDRAIN_BURST_EN
  localparam int START = 4;
`else
  localparam int START = 1;
`endif
  logic clock = 1'b0, reset, enable_in, m_ready_in;
  logic [3:0] len_in;
  logic [7:0] data_in, m_data_out;
  logic dequeue_out, accept_out, m_valid_out, busy_out;
  always #5 clock = ~clock;
  queue_drain_ctrl dut (
    .clock(clock), .reset(reset), .enable_in(enable_in), .len_in(len_in), .data_in(data_in),
    .dequeue_out(dequeue_out), .accept_out(accept_out), .m_data_out(m_data_out),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .busy_out(busy_out)
  );
  int checks = 0, errors = 0;
  logic [7:0] fifo[$], exp_q[$];
  bit deq_seen = 0, acc_m = 1, prev_stall = 0, prev_valid = 0, exp_pop = 0;
  logic [7:0] prev_data = '0;
  int pend = 0, cyc = 0, last_deq = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    if (deq_seen) begin
      exp_q.push_back(fifo.pop_front());
      data_in = exp_q[$];
    end
    len_in = 4'(fifo.size());
  endtask
  task automatic push(input logic [7:0] w);
    if (fifo.size() < 8) fifo.push_back(w);
    len_in = 4'(fifo.size());
  endtask
  initial forever begin
    @(negedge clock);
    cyc++;
    if (reset) begin
      chk("rst_deq", dequeue_out, 0);
      chk("rst_valid", m_valid_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_accept", accept_out, 1);
      chk("rst_data", m_data_out, 0);
      acc_m = 1; pend = 0; prev_stall = 0; prev_valid = 0; exp_pop = 0;
    end else begin
      chk("accept", accept_out, acc_m);
      chk("busy", busy_out, dequeue_out || pend != 0);
      if (exp_pop) chk("start", dequeue_out, 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid_out, 1);
        chk("stall_data", m_data_out, prev_data);
      end
      if (dequeue_out) begin
        chk("deq_len_nonzero", len_in != 0, 1);
        chk("one_outstanding", pend, 0);
        pend++;
        last_deq = cyc;
      end
      if (m_valid_out && !prev_valid) chk("latency", cyc - last_deq, DEQ_LAT + 1);
      if (m_valid_out && m_ready_in) begin
        if (exp_q.size() == 0) chk("spurious_word", 1, 0);
        else chk("data", m_data_out, exp_q.pop_front());
        pend--;
      end
      exp_pop = !busy_out && enable_in && len_in >= START;
      prev_stall = m_valid_out && !m_ready_in;
      prev_data = m_data_out;
      prev_valid = m_valid_out;
      acc_m = len_in >= 6 ? 1'b0 : len_in <= 2 ? 1'b1 : acc_m;
    end
    deq_seen = dequeue_out && !reset;
  end
  initial begin
    bit got;
    reset = 1; enable_in = 0; m_ready_in = 0; len_in = 0; data_in = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    enable_in = 1;
    repeat (20) step();
    m_ready_in = 1;
    push(8'h80);
    repeat (6) step();
    enable_in = 0;
    for (int i = 0; i < 8; i++) begin
      push(8'h90 + 8'(i));
      step();
    end
    chk("accept_full", accept_out, 0);
    enable_in = 1;
    repeat (40) step();
    m_ready_in = 0;
    push(8'h81);
    push(8'h82);
    repeat (14) step();
    m_ready_in = 1;
    repeat (10) step();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = deq_seen;
      step();
    end
    chk("deq_timeout", got, 1);
    reset = 1;
    #1;
    chk("async_deq", dequeue_out, 0);
    chk("async_valid", m_valid_out, 0);
    chk("async_busy", busy_out, 0);
    chk("async_data", m_data_out, 0);
    exp_q.delete();
    repeat (2) step();
    reset = 0;
    repeat (20) step();
    repeat (2000) begin
      if ($urandom_range(1) == 1) push(8'($urandom));
      m_ready_in = $urandom_range(3) != 0;
      enable_in = $urandom_range(7) != 0;
      step();
    end
    enable_in = 1;
    m_ready_in = 1;
    repeat (60) step();
    chk("drained", exp_q.size(), 0);
    chk("fifo_left", fifo.size() < START, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/queue_drain_ctrl.md
Name: queue_drain_ctrl

Overview:
- Sequencer between the serial deserializer/queue pair and a downstream byte consumer.
- Watches queue occupancy and issues single-cycle dequeue pulses.
- Captures the byte the queue presents and forwards it over a valid/ready handshake.
- Drives the deserializer's accept/status line with watermark hysteresis, so the sender pauses before the queue overflows.

Parameters:
- DATA_W, 8, width of the queue data word.
- LEN_W, 4, width of the queue occupancy count.
- DEPTH, 8, queue capacity in words; len_in never exceeds DEPTH.
- HIGH_WM, 6, occupancy at or above which accept_out deasserts.
- LOW_WM, 2, occupancy at or below which accept_out reasserts; requires LOW_WM < HIGH_WM.
- DEQ_LAT, 1, clock cycles from the dequeue_out pulse until data_in is valid and len_in has decremented; range 1..7.

Ports:
- clock, in, 1, single system clock; all logic is on the rising edge.
- reset, in, 1, asynchronous, active-high reset.
- enable_in, in, 1, permits new dequeues; a low level does not abort a transfer already in flight.
- len_in, in, LEN_W, queue occupancy.
- data_in, in, DATA_W, queue head word (the queue's data output).
- dequeue_out, out, 1, one-cycle pulse that pops the queue.
- accept_out, out, 1, status to the deserializer: the queue has room.
- m_data_out, out, DATA_W, captured word to the consumer.
- m_valid_out, out, 1, m_data_out is valid.
- m_ready_in, in, 1, consumer accepts the word.
- busy_out, out, 1, FSM is not in IDLE.

Behaviour:
- Reset is asynchronous and active-high and overrides everything.
- Reset values: dequeue_out=0, accept_out=1, m_data_out=0, m_valid_out=0, busy_out=0, state=IDLE, latency counter=0.
- Reset mid-transfer: any captured or in-flight word is discarded. The queue-side pop already issued is not undone.
- FSM states: IDLE, POP, WAIT, HOLD.
- IDLE -> POP when enable_in=1 and the start condition holds. The start condition is len_in != 0 (see Optional Feature for the burst variant).
- POP: dequeue_out=1 for exactly this cycle; load the latency counter with DEQ_LAT; -> WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 0, capture data_in into m_data_out, set m_valid_out=1, and go -> HOLD.
- HOLD: m_data_out and m_valid_out stay stable until m_ready_in=1 is sampled. On that edge, clear m_valid_out and choose the next state:
  - -> POP directly if the start condition still holds and enable_in=1;
  - otherwise -> IDLE.
  - Back-to-back throughput is one word per DEQ_LAT+2 cycles.
- At most one dequeue is outstanding at any time.
- dequeue_out is never asserted while len_in=0. If len_in reads 0 in WAIT, the capture still occurs; the queue is responsible for underflow.
- m_ready_in asserted while m_valid_out=0 is ignored.
- busy_out=1 in POP, WAIT and HOLD.
- accept_out hysteresis is registered and evaluated every cycle, independent of FSM state:
  - if len_in >= HIGH_WM, accept_out <= 0;
  - else if len_in <= LOW_WM, accept_out <= 1;
  - otherwise it holds its value.
  - When len_in=DEPTH, accept_out must already be 0.
- Width rules: len_in comparisons are unsigned at LEN_W. The latency counter is 3 bits.
- enable_in dropping during POP, WAIT or HOLD: the current word completes through HOLD, then the FSM enters IDLE.

Optional Feature:
- Macro QDRAIN_BURST_EN.
- Defined:
  - adds parameter BURST_LEN (default 4);
  - the IDLE start condition becomes len_in >= BURST_LEN;
  - once draining starts, the HOLD-to-POP continuation uses len_in != 0, so the queue drains completely before returning to IDLE.
  - A burst flag register tracks this and is cleared on reset and on entry to IDLE.
- Not defined: the start condition is always len_in != 0, and the burst flag logic is absent.

Decomposition:
- Package mc_pkg holds:
  - the state enum typedef (IDLE, POP, WAIT, HOLD);
  - default localparams for DATA_W, LEN_W and DEPTH;
  - a function checking that LOW_WM < HIGH_WM <= DEPTH.
- Sub-module flow_ctrl_wm contains the watermark hysteresis register. Its ports are clock, reset, len_in and accept_out, and it takes parameters HIGH_WM and LOW_WM.

Test Plan:
1. Reset held, then released with len_in=0: all outputs at reset values; no dequeue_out over 20 cycles.
2. len_in=1, data_in=8'h80, m_ready_in=1, DEQ_LAT=1: dequeue_out pulses once; m_valid_out rises 2 cycles after the pulse with m_data_out=8'h80.
3. len_in rising 0->8 then falling 8->0: accept_out falls at len 6, stays 0 through len 3, and returns to 1 at len 2.
4. m_ready_in held low for 10 cycles with word 8'h81: m_data_out and m_valid_out are stable for all 10 cycles; no second dequeue_out occurs.
5. Reset asserted mid-WAIT: outputs return to reset values immediately (asynchronously); after release the next word is handled normally.
6. With QDRAIN_BURST_EN, BURST_LEN=4:
   - len_in=3: no dequeue;
   - len_in=4: four consecutive transfers (8'h80..8'h83), then IDLE at len 0.
